// File: rtl/taus_pkg.sv
// Shared constants and step function for the
// combined three-component Tausworthe generator.
package taus_pkg;

    localparam int unsigned C1_Q = 13;
    localparam int unsigned C1_K = 19;
    localparam int unsigned C1_S = 12;
    localparam logic [31:0] C1_MASK = 32'hFFFFFFFE;

    localparam int unsigned C2_Q = 2;
    localparam int unsigned C2_K = 25;
    localparam int unsigned C2_S = 4;
    localparam logic [31:0] C2_MASK = 32'hFFFFFFF8;

    localparam int unsigned C3_Q = 3;
    localparam int unsigned C3_K = 11;
    localparam int unsigned C3_S = 17;
    localparam logic [31:0] C3_MASK = 32'hFFFFFFF0;

    // One Tausworthe component step; shifts truncate to 32 bits.
    function automatic logic [31:0] taus_step(
        input logic [31:0] s,
        input int unsigned q,
        input int unsigned k,
        input int unsigned sh,
        input logic [31:0] mask
    );
        logic [31:0] b;
        b = ((s << q) ^ s) >> k;
        return ((s & mask) << sh) ^ b;
    endfunction

    // Replace a seed whose significant bits are all zero,
    // since such a state would never leave zero.
    function automatic logic [31:0] guard_seed(
        input logic [31:0] seed,
        input logic [31:0] mask,
        input logic [31:0] fallback
    );
        return ((seed & mask) == 32'h0) ? fallback : seed;
    endfunction

endpackage

// File: rtl/taus_component.sv
// One Tausworthe component: state register with
// guarded seed load and single-step advance.
module taus_component
    import taus_pkg::*;
#(
    parameter int unsigned Q = 13,
    parameter int unsigned K = 19,
    parameter int unsigned S = 12,
    parameter logic [31:0] MASK = 32'hFFFFFFFE,
    parameter logic [31:0] SEED = 32'h00000002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] next
);

    logic [31:0] s_q;
    logic [31:0] s_d;

    // Next state of this component, also feeds the output word.
    always_comb begin
        next = taus_step(s_q, Q, K, S, MASK);
    end

    // Load has priority over advance; otherwise hold.
    always_comb begin
        s_d = s_q;
        if (load) begin
            s_d = guard_seed(seed, MASK, SEED);
        end else if (adv) begin
            s_d = next;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= SEED;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/tausworthe_combined.sv
// Combined taus88 generator with valid/ready output,
// runtime seed load and delivered-word counter.
module tausworthe_combined
    import taus_pkg::*;
#(
    parameter logic [31:0] SEED1 = 32'h00000002,
    parameter logic [31:0] SEED2 = 32'h00000008,
    parameter logic [31:0] SEED3 = 32'h00000010,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [31:0]      seed1,
    input  logic [31:0]      seed2,
    input  logic [31:0]      seed3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] word_cnt
);

    logic             adv;
    logic             xfer;
    logic [31:0]      n1;
    logic [31:0]      n2;
    logic [31:0]      n3;
    logic [31:0]      result;

    logic             valid_q;
    logic             valid_d;
    logic [31:0]      data_q;
    logic [31:0]      data_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Advance when enabled and the output slot is free or draining;
    // a seed load suppresses both advance and transfer.
    always_comb begin
        adv    = en & (~valid_q | out_ready) & ~seed_load;
        xfer   = valid_q & out_ready & ~seed_load;
        result = n1 ^ n2 ^ n3;
    end

    taus_component #(
        .Q(C1_Q), .K(C1_K), .S(C1_S),
        .MASK(C1_MASK), .SEED(SEED1)
    ) u_c1 (
        .clk(clk), .rst(rst),
        .load(seed_load), .seed(seed1),
        .adv(adv), .next(n1)
    );

    taus_component #(
        .Q(C2_Q), .K(C2_K), .S(C2_S),
        .MASK(C2_MASK), .SEED(SEED2)
    ) u_c2 (
        .clk(clk), .rst(rst),
        .load(seed_load), .seed(seed2),
        .adv(adv), .next(n2)
    );

    taus_component #(
        .Q(C3_Q), .K(C3_K), .S(C3_S),
        .MASK(C3_MASK), .SEED(SEED3)
    ) u_c3 (
        .clk(clk), .rst(rst),
        .load(seed_load), .seed(seed3),
        .adv(adv), .next(n3)
    );

    // Output slot and counter next-state.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (seed_load) begin
            valid_d = 1'b0;
            data_d  = 32'h0;
            cnt_d   = '0;
        end else begin
            if (xfer) begin
                valid_d = 1'b0;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            if (adv) begin
                valid_d = 1'b1;
                data_d  = result;
            end
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign word_cnt  = cnt_q;

endmodule

// File: doc/tausworthe_combined.md
Name: tausworthe_combined

Overview:
- Combined three-component Tausworthe uniform RNG (taus88 structure); successor to the single-component generator.
- Runtime seed loading with a degenerate-seed guard.
- Valid/ready output handshake with backpressure, and a delivered-word counter.
- Sits between the noise/test-pattern sources and any consumer that may stall, e.g. the FIFO or DAC formatter.

Parameters:
- SEED1, 32'h00000002, reset/fallback seed for component 1 (bits [31:1] must be non-zero)
- SEED2, 32'h00000008, reset/fallback seed for component 2 (bits [31:3] must be non-zero)
- SEED3, 32'h00000010, reset/fallback seed for component 3 (bits [31:4] must be non-zero)
- CNT_W, 32, width of the delivered-word counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  allow the generator to advance
- seed_load  in  1  single-cycle pulse: load seed1..seed3
- seed1  in  32  component 1 seed
- seed2  in  32  component 2 seed
- seed3  in  32  component 3 seed
- out_ready  in  1  consumer accepts out_data
- out_valid  out  1  out_data holds an unconsumed word
- out_data  out  32  random word
- word_cnt  out  CNT_W  number of handshakes completed since reset/seed load

Behaviour:
- Reset (async, active-high):
  - s1/s2/s3 = SEED1/SEED2/SEED3.
  - out_valid=0, out_data=0, word_cnt=0.
- Component step for component i (all 32-bit, shifts truncate):
  - b = ((s<<Q)^s)>>K
  - s' = ((s & MASK)<<S)^b
- Shift constants (Q, K, S, MASK):
  - C1: Q=13, K=19, S=12, MASK=FFFFFFFE
  - C2: Q=2, K=25, S=4, MASK=FFFFFFF8
  - C3: Q=3, K=11, S=17, MASK=FFFFFFF0
- Result = s1'^s2'^s3', computed from the next states.
- adv = en & (~out_valid | out_ready) & ~seed_load.
- On adv (single edge): s1..s3 <= s1'..s3', out_data <= result, out_valid <= 1.
- Latency: first valid word 1 cycle after en rises with the output empty. Sustained throughput is 1 word/cycle while out_ready=1.
- Handshake:
  - A transfer occurs when out_valid & out_ready; word_cnt increments on each transfer and wraps modulo 2^CNT_W.
  - If out_valid & ~out_ready: out_data and state hold stable, no advance.
  - If en=0 & out_ready & out_valid: transfer completes, out_valid <= 0.
- seed_load (highest priority):
  - s1..s3 <= guarded seeds; out_valid <= 0, out_data <= 0, word_cnt <= 0.
  - A pending word is discarded, even if out_ready=1 in the same cycle; that transfer is not counted.
  - Guard: if (seedi & MASKi)==0, SEEDi is used instead. Prevents the all-zero lock-up of that component.
- Simultaneous en & seed_load: load wins, no advance that cycle. Generation restarts the next cycle.
- Reset mid-stream: immediate return to reset values, no partial word.

Decomposition:
- Package taus_pkg: Q/K/S/MASK constants for the three components, and a function taus_step(s, q, k, sh, mask) returning s'.
- Sub-module taus_component: one state register with load, guard, and advance ports, instantiated three times.
- The top level holds the handshake, output register and counter.

Test Plan:
- Reset then en=1, out_ready=1 with default seeds:
  - 1st out_data=32'h00202080, 2nd 32'h02002C80.
  - Further words match a C taus88 model for 10000 words; word_cnt=10000.
- Backpressure: out_ready=0 for 5 cycles after 1st word -> out_valid=1 and out_data=32'h00202080 held; word_cnt=0. Release -> sequence continues 32'h02002C80 with no skipped word.
- seed_load with seed1=1, seed2=7, seed3=15 (all degenerate) -> behaves as default seeds; next word=32'h00202080, word_cnt=0.
- seed_load asserted with en=1 while out_valid=1, out_ready=1 -> no transfer counted, out_valid=0 next cycle. Sequence restarts from the new seeds.
- Async rst asserted mid-stream between clock edges -> out_valid=0, out_data=0, word_cnt=0 immediately. After release, first word=32'h00202080.
- en toggled randomly with random out_ready -> accepted words equal the model sequence in order; word_cnt equals the handshake count.
